// File: rtl/aes_sub_bytes_seq.sv
// rtl/aes_sub_bytes_seq.sv - iterative AES forward SubBytes, 4 bytes per cycle (option macro: AES_SUBBYTES_PIPE_EN)
module aes_sub_bytes_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

`ifdef AES_SUBBYTES_PIPE_EN
   // One extra BUSY cycle: word cnt is looked up while word cnt-1 is written.
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] LAST = 3'd4;
`else
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] LAST = 2'd3;
`endif
   localparam logic [CNT_W-1:0] ONE = 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt;
   logic [127:0]     work;
   logic [1:0]       rd_idx;
   logic [31:0]      rd_word;
   logic [31:0]      sub_word;
   logic [1:0]       wr_idx;
   logic [31:0]      wr_word;
   logic             wr_en;
   logic             accept;

   // Four parallel byte lookups on the selected word.
   assign sub_word = {SBOX[rd_word[31:24]], SBOX[rd_word[23:16]],
                      SBOX[rd_word[15:8]],  SBOX[rd_word[7:0]]};
   assign rd_idx   = cnt[1:0];
   assign state_out = work;

   // Select the word being looked up; word 0 is the most significant.
   always_comb begin
      rd_word = work[127:96];
      case (rd_idx)
         2'd1:    rd_word = work[95:64];
         2'd2:    rd_word = work[63:32];
         2'd3:    rd_word = work[31:0];
         default: rd_word = work[127:96];
      endcase
   end

`ifdef AES_SUBBYTES_PIPE_EN
   logic [31:0]      pipe;
   logic [CNT_W-1:0] cnt_m1;

   assign cnt_m1  = cnt - ONE;
   assign wr_idx  = cnt_m1[1:0];
   assign wr_word = pipe;
   assign wr_en   = (state == BUSY) && (cnt != '0);

   // Register the lookup result; the write of this word happens next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pipe <= '0;
      else if (state == BUSY)
         pipe <= sub_word;
   end
`else
   assign wr_idx  = cnt;
   assign wr_word = sub_word;
   assign wr_en   = (state == BUSY);
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state and handshake outputs; DONE refuses new input until drained.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (cnt == LAST)
               next_state = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Word counter: cleared on accept, advances once per BUSY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (accept)
         cnt <= '0;
      else if (state == BUSY)
         cnt <= cnt + ONE;
   end

   // Working register: load on accept, then overwrite one word per cycle in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         work <= '0;
      else if (accept)
         work <= state_in;
      else if (wr_en) begin
         for (int i = 0; i < 4; i++)
            if (wr_idx == i[1:0])
               work[127-32*i -: 32] <= wr_word;
      end
   end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb/tb_aes_sub_bytes_seq.sv - scoreboard bench for aes_sub_bytes_seq (honours AES_SUBBYTES_PIPE_EN)
`timescale 1ns/1ps
module tb_aes_sub_bytes_seq;

`ifdef AES_SUBBYTES_PIPE_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 4;
`endif
   localparam int PERIOD = LAT + 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] state_in = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [127:0] state_out;

   int           errors = 0;
   int           checks = 0;
   logic [7:0]   sbox_m [256];
   logic [127:0] exp_q [$];

   aes_sub_bytes_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic       hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gf_mul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] sub_state_m(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_m[s[127-8*i -: 8]];
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Offer s until accepted; leaves time at accept edge + 1.
   task automatic send(input logic [127:0] s);
      int   n;
      logic acc;
      n = 0;
      state_in = s;
      in_valid = 1'b1;
      exp_q.push_back(sub_state_m(s));
      do begin
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 50);
      in_valid = 1'b0;
      check1("accept", acc, 1'b1);
   endtask

   // Wait for out_valid, check latency and pop the scoreboard.
   task automatic wait_result(input string tag);
      int           n;
      logic [127:0] exp;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_int({tag, "_latency"}, n, LAT);
      check1({tag, "_out_valid"}, out_valid, 1'b1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'bx;
      check({tag, "_data"}, state_out, exp);
   endtask

   initial begin
      logic [127:0] v, held, rt, s;
      for (int i = 0; i < 256; i++) sbox_m[i] = fwd_sbox(i[7:0]);

      // Reset then idle
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check1("rst_in_ready", in_ready, 1'b1);
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check("rst_state_out", state_out, 128'h0);

      // Full-table vector
      v = 128'h00112233445566778899AABBCCDDEEFF;
      out_ready = 1'b1;
      send(v);
      check1("busy_after_accept", busy, 1'b1);
      check1("in_ready_busy", in_ready, 1'b0);
      wait_result("vec");
      check("vec_const", state_out, 128'h638293C31BFC33F5C4EEACEA4BC12816);
      @(posedge clk); #1;
      check1("vec_in_ready_after_hs", in_ready, 1'b1);
      check1("vec_out_valid_after_hs", out_valid, 1'b0);

      // Backpressure
      out_ready = 1'b0;
      send(v);
      wait_result("bp");
      held = state_out;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         state_in = ~v;
         @(posedge clk); #1;
         check1("bp_out_valid_hold", out_valid, 1'b1);
         check("bp_state_hold", state_out, held);
         check1("bp_in_ready_low", in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check1("bp_out_valid_drop", out_valid, 1'b0);
      check1("bp_in_ready_back", in_ready, 1'b1);
      check1("bp_busy_clear", busy, 1'b0);

      // Mid-operation reset
      send(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check1("mrst_in_ready", in_ready, 1'b1);
      check1("mrst_out_valid", out_valid, 1'b0);
      check1("mrst_busy", busy, 1'b0);
      check("mrst_state_out", state_out, 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send({16{8'h53}});
      wait_result("mrst_new");
      check("mrst_const", state_out, {16{8'hED}});
      @(posedge clk); #1;

      // Back-to-back streaming
      fork
         begin
            for (int k = 0; k < 100; k++)
               send({$urandom, $urandom, $urandom, $urandom});
         end
         begin
            int got, last, cyc;
            logic [127:0] exp;
            got = 0; last = -1; cyc = 0;
            while (got < 100 && cyc < 2000) begin
               @(posedge clk); #1;
               cyc++;
               if (out_valid) begin
                  exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'bx;
                  check("stream_data", state_out, exp);
                  if (last >= 0) check_int("stream_interval", cyc - last, PERIOD);
                  last = cyc;
                  got++;
               end
            end
            check_int("stream_count", got, 100);
         end
      join
      @(posedge clk); #1;
      check_int("stream_queue_empty", exp_q.size(), 0);

      // Round-trip over all 256 byte values
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < 16; i++) s[127-8*i -: 8] = 8'(16 * k + i);
         send(s);
         wait_result("rt");
         for (int i = 0; i < 16; i++) rt[127-8*i -: 8] = inv_sbox(state_out[127-8*i -: 8]);
         check("roundtrip", rt, s);
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_sub_bytes_seq.md
# aes_sub_bytes_seq

- Iterative forward SubBytes engine for the AES-128 encryption datapath: the encrypt-side counterpart of the decrypt-side inverse S-box.
- Takes a 128-bit state and applies the FIPS-197 forward S-box to all 16 bytes, using four byte lookups per cycle over four cycles.
- Uses valid/ready handshakes on both sides and sits between AddRoundKey and ShiftRows in the round datapath.

## Interface
- No parameters; width is fixed at 128 bits, 4 bytes per cycle.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  engine can accept a state (IDLE only)
- state_in  input  128  input state; byte 0 = [127:120], byte 15 = [7:0]
- out_valid  output  1  state_out holds a completed result
- out_ready  input  1  consumer accepts state_out
- state_out  output  128  substituted state, same byte order
- busy  output  1  high in BUSY or DONE

## Operation
- Four internal 256-entry forward S-box lookups implement the FIPS-197 table, e.g. S(00)=63, S(01)=7C, S(53)=ED, S(FF)=16.
- One 128-bit working register; state_out is driven directly from it.
- One 2-bit word counter (3-bit with pipe option).
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - in_ready=1.
  - in_valid=1: capture state_in into the working register, clear the counter, go to BUSY.
- BUSY
  - Each cycle, word cnt (bits [127-32*cnt -: 32]) is replaced with its 4 substituted bytes; cnt increments.
  - After the cnt==3 write, go to DONE.
  - in_valid is ignored.
- DONE
  - out_valid=1; state_out is held stable.
  - out_ready=1: go to IDLE.
  - No new input is accepted in the same cycle (in_ready stays 0 in DONE).
- Reset, asserted at any time including mid-BUSY: FSM to IDLE, counter 0, working register 0. The in-flight state is discarded with no output.
- Reset values: in_ready=1 (follows IDLE), out_valid=0, busy=0, state_out=128'h0.
- Bytes are never mixed or reordered; byte i of the output is S(byte i of the input).

## Timing
- Accept on edge E0 (in_valid & in_ready). Words 0..3 are written on edges E1..E4.
- out_valid rises after E4: 4-cycle latency in the base build.
- out_valid remains high until sampled with out_ready=1. The FSM is in IDLE (in_ready=1) the cycle after the handshake edge.
- Maximum throughput: one state per 6 cycles (accept, 4 BUSY, 1 DONE with out_ready already high).
- out_ready may be held high permanently; out_valid is then high for exactly one cycle per result.
- The consumer may stall indefinitely in DONE; state_out must not change while stalled.
- Words already written before a mid-BUSY reset are irrelevant: reset wins.

## Configuration
- AES_SUBBYTES_PIPE_EN
  - Defined: a 32-bit register is inserted between the S-box outputs and the working-register write.
  - BUSY then lasts 5 cycles (cnt 0..4): lookup of word cnt is registered, and word cnt-1 is written.
  - out_valid rises after E5; latency is 5 cycles and throughput one per 7 cycles.
  - The pipe register resets to 0.
- Not defined: combinational lookup-to-writeback, latency 4, as above.
- Results are bit-identical in both builds.

## Test plan
- Reset then idle
  - Release rst_n; hold in_valid=0.
  - Required: in_ready=1, out_valid=0, busy=0, state_out=0.
- Full-table vector
  - state_in=00112233445566778899AABBCCDDEEFF.
  - Required: after 4 cycles (5 with pipe), state_out=638293C31BFC33F5C4EEACEA4BC12816 with out_valid=1.
- Backpressure
  - Same vector with out_ready=0 for 10 cycles.
  - Required: out_valid and state_out stable; in_valid pulses during the stall are not accepted.
  - Raise out_ready: one handshake, then in_ready=1 on the next cycle.
- Mid-operation reset
  - Assert rst_n=0 two cycles after accept.
  - Required: outputs return to reset values immediately; after release, a new vector 53535353...53 yields EDEDED...ED.
- Back-to-back streaming
  - out_ready held 1; 100 random states offered continuously.
  - Required: each output equals a software forward S-box of its input, in order, one result per 6 cycles (7 with pipe), with no drops or duplicates.
- Round-trip with the inverse S-box model
  - All 256 byte values across 16 states.
  - Required: InvSbox(S(x))==x for every byte.
